csr_ex_ctrl: RTL and testbench
==============================

# csr_ex_ctrl

Exception and flush sequencer between the WB stage and the CSR file. Each cycle it takes at most one retiring instruction from WB and ranks its events: pending interrupt, synchronous exception, `ertn`, CSR write. It drives the CSR file's single write/exception/ertn port, then runs a redirect handshake with the fetch stage. It also discards wrong-path WB traffic until fetch accepts the new PC.

## Interface

Parameters:
- `DRAIN_CYCLES`, default 2: cycles WB input stays ignored after the redirect handshake completes. Legal range 0–15.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `wb_valid` in 1: WB holds a retiring instruction.
- `wb_ready` out 1: instruction accepted this cycle. Equals `state==IDLE`.
- `wb_pc_in` in 32: PC of the WB instruction.
- `wb_ex_req` in 1: instruction raised a synchronous exception.
- `wb_ecode_in` in 6, `wb_esubcode_in` in 9, `wb_vaddr_in` in 32: exception info.
- `wb_ertn` in 1: instruction is `ertn`.
- `wb_csr_we` in 1, `wb_csr_num` in 14, `wb_csr_wmask` in 32, `wb_csr_wvalue` in 32: CSR write request.
- `has_int` in 1: CSR interrupt pending.
- `ex_entry` in 32, `era` in 32: CSR outputs.
- `csr_we` out 1, `csr_num` out 14, `csr_wmask` out 32, `csr_wvalue` out 32: to CSR.
- `wb_ex` out 1, `wb_pc` out 32, `wb_vaddr` out 32, `wb_ecode` out 6, `wb_esubcode` out 9, `ertn_flush` out 1: to CSR.
- `flush` out 1: one-cycle pipeline kill.
- `redirect_valid` out 1, `redirect_pc` out 32, `redirect_ready` in 1: fetch redirect handshake.
- `flush_cnt` out 16: count of flushes taken. Wraps.

## Operation

- States: `IDLE`, `REDIRECT`, `DRAIN`.
- An instruction is accepted when `IDLE && wb_valid`. Priority among its events, highest first:
  - interrupt (`has_int`): `wb_ex=1`, `wb_ecode=ECODE_INT` (0x00), `wb_esubcode=0`, `wb_pc=wb_pc_in`.
  - `wb_ex_req`: `wb_ex=1`, with ecode, esubcode and vaddr taken from the inputs.
  - `wb_ertn`: `ertn_flush=1`.
  - `wb_csr_we`: `csr_we=1`, and `csr_num`/`csr_wmask`/`csr_wvalue` pass through.
- Only the highest-ranked event fires. In particular, `csr_we` is forced to 0 whenever `wb_ex` or `ertn_flush` fires.
- When `wb_ex` fires:
  - `flush=1`;
  - `redirect_pc` is loaded with `ex_entry` (sampled this cycle);
  - `flush_cnt` increments;
  - next state is `REDIRECT`.
- When `ertn_flush` fires, the same happens except `redirect_pc` is loaded with `era`.
- A plain CSR write or a normal retire stays in `IDLE`.
- `REDIRECT`:
  - `redirect_valid=1`, with `redirect_pc` held stable.
  - On `redirect_ready`, go to `DRAIN` with the counter loaded to `DRAIN_CYCLES`. If `DRAIN_CYCLES==0`, go straight to `IDLE`.
  - `wb_valid` is ignored: no CSR side effects and `wb_ready=0`.
- `DRAIN`: WB is ignored while the counter decrements. Return to `IDLE` when it reaches 1 (i.e. exactly `DRAIN_CYCLES` cycles).
- `has_int` is consulted only when an instruction is accepted. An interrupt with no valid WB instruction waits.
- `wb_pc`, `wb_vaddr`, `wb_ecode`, `wb_esubcode` and `csr_*` data are combinational passthrough. They are qualified only by the strobes.

## Timing

- Reset (synchronous, active-high) forces:
  - state `IDLE`;
  - `flush_cnt=0`, `redirect_pc=0`, drain counter 0;
  - all strobes (`csr_we`, `wb_ex`, `ertn_flush`, `flush`, `redirect_valid`) 0.
- Reset in `REDIRECT` or `DRAIN` abandons the redirect. No `redirect_valid` appears in the cycle after reset.
- Strobes are combinational and appear in the acceptance cycle. The CSR file updates at the following edge.
- `redirect_valid` rises exactly 1 cycle after `flush`. It stays high until the cycle in which `redirect_ready=1`, inclusive.
- If `redirect_ready` is already high at the first `REDIRECT` cycle, the handshake completes in that cycle.
- Earliest next acceptance after a flush: `flush` cycle + 2 + `DRAIN_CYCLES`.
- `flush_cnt` wraps 0xFFFF→0x0000.
- Simultaneous events are resolved only by the priority above. `wb_ex_req` and `wb_ertn` both high → exception wins.

## Structure

- `macros.h` holds the shared constants: `ECODE_INT` and the other ecodes, the CSR numbers, and the state encoding `EXC_IDLE/EXC_REDIRECT/EXC_DRAIN` (2 bits).
- Natural sub-module: `ex_prio_enc`. It is combinational: it takes `{has_int, wb_ex_req, wb_ertn, wb_csr_we}` and produces a one-hot event plus ecode/esubcode.
- The FSM, redirect register and counters stay in `csr_ex_ctrl`.

## Test plan

- Interrupt vs. exception:
  - Stimulus: `wb_valid=1`, `has_int=1`, `wb_ex_req=1` (ecode 0x0B), `wb_pc_in=0x1c000100`, `ex_entry=0x1c008000`.
  - Response: in the same cycle `wb_ex=1`, `wb_ecode=0x00`, `flush=1`, `csr_we=0`. Next cycle `redirect_valid=1`, `redirect_pc=0x1c008000`.
- `ertn`:
  - Stimulus: `wb_ertn=1`, `era=0x1c000200`, `redirect_ready` held 0 for 3 cycles.
  - Response: `ertn_flush` pulses for 1 cycle. `redirect_valid` stays high with PC 0x1c000200 for 4 cycles (3 waiting, 1 handshake). `flush_cnt=1`.
- CSR write:
  - Stimulus: `wb_csr_we=1`, `num=0x30`, `wmask=0xFFFF0000`, `wvalue=0x12345678`.
  - Response: `csr_we=1` with those values passed through. No flush. State stays `IDLE`.
- Drain with `DRAIN_CYCLES=2`:
  - Stimulus: exception taken, `redirect_ready=1` immediately, `wb_valid` held high with `wb_csr_we=1`.
  - Response: `wb_ready=0` and `csr_we=0` for 3 cycles after `flush`. Acceptance resumes in the 4th cycle.
- Reset mid-redirect:
  - Stimulus: assert `reset` in the 2nd `REDIRECT` cycle.
  - Response: the next cycle shows `redirect_valid=0`, `flush_cnt=0` and `wb_ready=1`.
- Counter wrap: preload 0xFFFF flushes via 65535 exceptions (or force) → the next flush gives `flush_cnt=0x0000`.

Source files
------------

// File: rtl/csr_ex_ctrl_pkg.sv
// Shared constants for the exception/flush sequencer: ecodes, FSM encoding
// and the bit positions of the one-hot event vector from the priority encoder.
package csr_ex_ctrl_pkg;

    localparam logic [5:0] ECODE_INT = 6'h00;

    localparam logic [1:0] EXC_IDLE     = 2'd0;
    localparam logic [1:0] EXC_REDIRECT = 2'd1;
    localparam logic [1:0] EXC_DRAIN    = 2'd2;

    localparam int EV_INT  = 3;
    localparam int EV_EXC  = 2;
    localparam int EV_ERTN = 1;
    localparam int EV_CSR  = 0;

endpackage

// File: rtl/csr_ex_ctrl_prio.sv
// Ranks the events of one retiring instruction (interrupt > exception > ertn >
// CSR write) into a one-hot vector, and picks the ecode/esubcode to report.
module ex_prio_enc
    import csr_ex_ctrl_pkg::*;
(
    input  logic       has_int,
    input  logic       ex_req,
    input  logic       ertn,
    input  logic       csr_we,
    input  logic [5:0] ecode_in,
    input  logic [8:0] esubcode_in,
    output logic [3:0] ev,
    output logic [5:0] ecode,
    output logic [8:0] esubcode
);

    always_comb begin
        ev       = '0;
        ecode    = ecode_in;
        esubcode = esubcode_in;
        if (has_int) begin
            ev[EV_INT] = 1'b1;
            ecode      = ECODE_INT;
            esubcode   = '0;
        end else if (ex_req) begin
            ev[EV_EXC] = 1'b1;
        end else if (ertn) begin
            ev[EV_ERTN] = 1'b1;
        end else if (csr_we) begin
            ev[EV_CSR] = 1'b1;
        end
    end

endmodule

// File: rtl/csr_ex_ctrl.sv
// Exception/flush sequencer between WB and the CSR file: drives the CSR
// write/exception/ertn strobes, then a redirect handshake plus a WB drain window.
module csr_ex_ctrl
    import csr_ex_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [31:0] wb_pc_in,
    input  logic        wb_ex_req,
    input  logic [5:0]  wb_ecode_in,
    input  logic [8:0]  wb_esubcode_in,
    input  logic [31:0] wb_vaddr_in,
    input  logic        wb_ertn,
    input  logic        wb_csr_we,
    input  logic [13:0] wb_csr_num,
    input  logic [31:0] wb_csr_wmask,
    input  logic [31:0] wb_csr_wvalue,
    input  logic        has_int,
    input  logic [31:0] ex_entry,
    input  logic [31:0] era,
    output logic        csr_we,
    output logic [13:0] csr_num,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        wb_ex,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_vaddr,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic        ertn_flush,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic [15:0] flush_cnt
);

    logic [1:0]  state_reg, state_next;
    logic [3:0]  drain_cnt_reg, drain_cnt_next;
    logic [31:0] redirect_pc_reg, redirect_pc_next;
    logic [15:0] flush_cnt_reg, flush_cnt_next;
    logic [3:0]  ev;
    logic        accept;

    ex_prio_enc u_prio (
        .has_int     (has_int),
        .ex_req      (wb_ex_req),
        .ertn        (wb_ertn),
        .csr_we      (wb_csr_we),
        .ecode_in    (wb_ecode_in),
        .esubcode_in (wb_esubcode_in),
        .ev          (ev),
        .ecode       (wb_ecode),
        .esubcode    (wb_esubcode)
    );

    // Strobes are held low during the reset cycle even if WB presents work.
    assign accept     = (state_reg == EXC_IDLE) && wb_valid && !reset;
    assign wb_ready   = (state_reg == EXC_IDLE);
    assign wb_ex      = accept && (ev[EV_INT] || ev[EV_EXC]);
    assign ertn_flush = accept && ev[EV_ERTN];
    assign csr_we     = accept && ev[EV_CSR];
    assign flush      = wb_ex || ertn_flush;

    assign wb_pc      = wb_pc_in;
    assign wb_vaddr   = wb_vaddr_in;
    assign csr_num    = wb_csr_num;
    assign csr_wmask  = wb_csr_wmask;
    assign csr_wvalue = wb_csr_wvalue;

    assign redirect_valid = (state_reg == EXC_REDIRECT);
    assign redirect_pc    = redirect_pc_reg;
    assign flush_cnt      = flush_cnt_reg;

    always_comb begin
        state_next       = state_reg;
        drain_cnt_next   = drain_cnt_reg;
        redirect_pc_next = redirect_pc_reg;
        flush_cnt_next   = flush_cnt_reg;
        case (state_reg)
            EXC_IDLE: begin
                if (flush) begin
                    state_next       = EXC_REDIRECT;
                    redirect_pc_next = wb_ex ? ex_entry : era;
                    flush_cnt_next   = flush_cnt_reg + 16'd1;
                end
            end
            EXC_REDIRECT: begin
                if (redirect_ready) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_next = EXC_IDLE;
                    end else begin
                        state_next     = EXC_DRAIN;
                        drain_cnt_next = 4'(DRAIN_CYCLES);
                    end
                end
            end
            EXC_DRAIN: begin
                if (drain_cnt_reg <= 4'd1) begin
                    state_next     = EXC_IDLE;
                    drain_cnt_next = '0;
                end else begin
                    drain_cnt_next = drain_cnt_reg - 4'd1;
                end
            end
            default: state_next = EXC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= EXC_IDLE;
            drain_cnt_reg   <= '0;
            redirect_pc_reg <= '0;
            flush_cnt_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            drain_cnt_reg   <= drain_cnt_next;
            redirect_pc_reg <= redirect_pc_next;
            flush_cnt_reg   <= flush_cnt_next;
        end
    end

endmodule

// File: tb/tb_csr_ex_ctrl.sv
// Directed plus randomized bench for csr_ex_ctrl, checked against a cycle-count
// reference model (redirect pending flag + cycles-left-blocked counter).
module tb_csr_ex_ctrl;

    localparam int DRAIN = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_pc_in;
    logic        wb_ex_req;
    logic [5:0]  wb_ecode_in;
    logic [8:0]  wb_esubcode_in;
    logic [31:0] wb_vaddr_in;
    logic        wb_ertn;
    logic        wb_csr_we;
    logic [13:0] wb_csr_num;
    logic [31:0] wb_csr_wmask;
    logic [31:0] wb_csr_wvalue;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] era;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic        ertn_flush;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic [15:0] flush_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit          m_redir;
    logic [31:0] m_pc;
    logic [15:0] m_cnt;
    int          m_block;

    always #5 clk = ~clk;

    csr_ex_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc_in(wb_pc_in),
        .wb_ex_req(wb_ex_req), .wb_ecode_in(wb_ecode_in),
        .wb_esubcode_in(wb_esubcode_in), .wb_vaddr_in(wb_vaddr_in),
        .wb_ertn(wb_ertn), .wb_csr_we(wb_csr_we), .wb_csr_num(wb_csr_num),
        .wb_csr_wmask(wb_csr_wmask), .wb_csr_wvalue(wb_csr_wvalue),
        .has_int(has_int), .ex_entry(ex_entry), .era(era),
        .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask),
        .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_pc(wb_pc),
        .wb_vaddr(wb_vaddr), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .ertn_flush(ertn_flush), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .flush_cnt(flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        wb_valid = 0; wb_ex_req = 0; wb_ertn = 0; wb_csr_we = 0; has_int = 0;
        redirect_ready = 0;
    endtask

    // Called at a negedge with inputs applied: checks outputs, advances model.
    task automatic cycle();
        bit ready_e, acc, is_int, is_exc, is_ertn, is_csr;
        #1;
        ready_e = !m_redir && (m_block == 0);
        acc     = ready_e && wb_valid && !reset;
        is_int  = acc && has_int;
        is_exc  = acc && !has_int && wb_ex_req;
        is_ertn = acc && !has_int && !wb_ex_req && wb_ertn;
        is_csr  = acc && !has_int && !wb_ex_req && !wb_ertn && wb_csr_we;
        check("wb_ready", 32'(wb_ready), 32'(ready_e));
        check("wb_ex", 32'(wb_ex), 32'(is_int || is_exc));
        check("ertn_flush", 32'(ertn_flush), 32'(is_ertn));
        check("csr_we", 32'(csr_we), 32'(is_csr));
        check("flush", 32'(flush), 32'(is_int || is_exc || is_ertn));
        check("redirect_valid", 32'(redirect_valid), 32'(m_redir));
        check("redirect_pc", redirect_pc, m_pc);
        check("flush_cnt", 32'(flush_cnt), 32'(m_cnt));
        if (is_int || is_exc) begin
            check("wb_ecode", 32'(wb_ecode), is_int ? 32'h0 : 32'(wb_ecode_in));
            check("wb_esubcode", 32'(wb_esubcode), is_int ? 32'h0 : 32'(wb_esubcode_in));
            check("wb_pc", wb_pc, wb_pc_in);
            check("wb_vaddr", wb_vaddr, wb_vaddr_in);
        end
        if (is_csr) begin
            check("csr_num", 32'(csr_num), 32'(wb_csr_num));
            check("csr_wmask", csr_wmask, wb_csr_wmask);
            check("csr_wvalue", csr_wvalue, wb_csr_wvalue);
        end
        if (reset) begin
            m_redir = 0; m_pc = '0; m_cnt = '0; m_block = 0;
        end else if (m_redir) begin
            if (redirect_ready) begin
                m_redir = 0;
                m_block = DRAIN;
            end
        end else if (m_block > 0) begin
            m_block--;
        end else if (is_int || is_exc || is_ertn) begin
            m_redir = 1;
            m_pc    = is_ertn ? era : ex_entry;
            m_cnt   = m_cnt + 16'd1;
        end
        @(negedge clk);
    endtask

    task automatic settle();
        idle_inputs();
        redirect_ready = 1;
        for (int i = 0; i < 20 && (m_redir || m_block != 0); i++) cycle();
        redirect_ready = 0;
    endtask

    initial begin
        m_redir = 0; m_pc = '0; m_cnt = '0; m_block = 0;
        reset = 1;
        idle_inputs();
        wb_pc_in = 32'h1c000100; wb_ecode_in = 6'h0B; wb_esubcode_in = 9'h0;
        wb_vaddr_in = 32'h0; wb_csr_num = 14'h0; wb_csr_wmask = 32'h0;
        wb_csr_wvalue = 32'h0; ex_entry = 32'h1c008000; era = 32'h1c000200;
        @(negedge clk);
        wb_valid = 1; wb_csr_we = 1;
        cycle();                       // reset cycle: strobes must stay low
        reset = 0;
        idle_inputs();
        cycle();

        // Interrupt beats exception; CSR write suppressed
        wb_valid = 1; has_int = 1; wb_ex_req = 1; wb_csr_we = 1;
        cycle();
        idle_inputs();
        check("int_redirect_pc", redirect_pc, 32'h1c008000);
        redirect_ready = 1;
        cycle();
        settle();

        // ertn with fetch stalling 3 cycles
        wb_valid = 1; wb_ertn = 1;
        cycle();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            redirect_ready = (i == 3);
            check("ertn_rv_hold", 32'(redirect_valid), 32'h1);
            check("ertn_pc_hold", redirect_pc, 32'h1c000200);
            cycle();
        end
        check("ertn_cnt", 32'(flush_cnt), 32'h2);
        settle();

        // Plain CSR write passes through, no flush
        wb_valid = 1; wb_csr_we = 1; wb_csr_num = 14'h30;
        wb_csr_wmask = 32'hFFFF0000; wb_csr_wvalue = 32'h12345678;
        cycle();
        cycle();

        // Drain window: exception then WB keeps offering CSR writes
        wb_ex_req = 1; redirect_ready = 1;
        cycle();
        wb_ex_req = 0;
        for (int i = 0; i < 4; i++) cycle();
        check("drain_resumed", 32'(m_redir || m_block != 0), 32'h0);

        // Reset in the 2nd REDIRECT cycle
        idle_inputs();
        wb_valid = 1; wb_ex_req = 1;
        cycle();
        idle_inputs();
        cycle();
        reset = 1;
        cycle();
        reset = 0;
        check("rst_rv", 32'(redirect_valid), 32'h0);
        check("rst_cnt", 32'(flush_cnt), 32'h0);
        check("rst_ready", 32'(wb_ready), 32'h1);
        cycle();

        // Counter wrap
        force dut.flush_cnt_reg = 16'hFFFF;
        #1;
        release dut.flush_cnt_reg;
        m_cnt = 16'hFFFF;
        wb_valid = 1; wb_ex_req = 1;
        cycle();
        idle_inputs();
        check("wrap_cnt", 32'(flush_cnt), 32'h0);
        settle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset          = ($urandom_range(0, 199) == 0);
            wb_valid       = ($urandom_range(0, 3) != 0);
            has_int        = ($urandom_range(0, 15) == 0);
            wb_ex_req      = ($urandom_range(0, 7) == 0);
            wb_ertn        = ($urandom_range(0, 7) == 0);
            wb_csr_we      = ($urandom_range(0, 1) == 1);
            redirect_ready = ($urandom_range(0, 2) == 0);
            wb_pc_in       = $urandom;
            wb_vaddr_in    = $urandom;
            wb_ecode_in    = 6'($urandom);
            wb_esubcode_in = 9'($urandom);
            wb_csr_num     = 14'($urandom);
            wb_csr_wmask   = $urandom;
            wb_csr_wvalue  = $urandom;
            ex_entry       = $urandom;
            era            = $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
